// File: rtl/frame_reader.sv
// frame_reader
//   Runs one capture-and-read batch per cpu_start request. The module triggers
//   the capture stage and waits until the line RAM is full. It then streams
//   WORDS words out of the line RAM into a small output FIFO, which the
//   processor bus drains one word per cpu_rd pop.
//
// Parameters
//   DW    : data bus MSB index (word width DW+1)
//   AW    : address bus MSB index
//   WORDS : RAM words read per batch (1..2^(AW+1))
//   FD    : output FIFO depth (power of two, >= 2)
//
// Ports
//   clk, reset_sync : clock; asynchronous active-high reset
//   cpu_start       : one-cycle request to capture and read one batch
//   c_trigg, c_done : capture trigger out / capture-stage RAM-full in
//   ram_addr/ram_data/ram_sel : line RAM read port (data one cycle after address)
//   cpu_rd, cpu_data, cpu_valid : FIFO pop strobe, head word, not-empty flag
//   busy, batch_done : not idle; one-cycle pulse at batch completion
//
// Build option
//   BYTE_SWAP_EN : when defined, the two low bytes of each word are exchanged
//                  before the push. This build needs DW >= 15. Latency is the
//                  same in both builds.

module frame_reader #(
    parameter int DW    = 15,
    parameter int AW    = 11,
    parameter int WORDS = 320,
    parameter int FD    = 4
) (
    input  logic          clk,
    input  logic          reset_sync,
    input  logic          cpu_start,
    output logic          c_trigg,
    input  logic          c_done,
    output logic [AW:0]   ram_addr,
    input  logic [DW:0]   ram_data,
    output logic          ram_sel,
    input  logic          cpu_rd,
    output logic [DW:0]   cpu_data,
    output logic          cpu_valid,
    output logic          busy,
    output logic          batch_done
);

    localparam int PW = (FD > 1) ? $clog2(FD) : 1;

    localparam logic [AW:0] LastAddr = (AW + 1)'(WORDS - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StTrig     = 3'd1;
    localparam logic [2:0] StWaitFull = 3'd2;
    localparam logic [2:0] StFetch    = 3'd3;
    localparam logic [2:0] StDrain    = 3'd4;
    localparam logic [2:0] StDone     = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [AW:0]   addr_q, addr_d;
    logic          all_issued_q, all_issued_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic [DW:0]   mem [FD];

    logic          issue;
    logic          push;
    logic          pop;
    logic [DW:0]   push_word;

    // At most one read is ever in flight, so counting it as one slot guarantees
    // that the word finds room in the FIFO when it returns one cycle later.
    assign issue = (state_q == StFetch) && !all_issued_q &&
                   ((int'(count_q) + int'(inflight_q)) < FD);
    assign push  = inflight_q;
    assign pop   = cpu_rd && (count_q != '0);

    always_comb begin
`ifdef BYTE_SWAP_EN
        push_word       = ram_data;
        push_word[15:0] = {ram_data[7:0], ram_data[15:8]};
`else
        push_word       = ram_data;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (cpu_start) state_d = StTrig;
            StTrig:     if (!c_done) state_d = StWaitFull;
            StWaitFull: if (c_done) state_d = StFetch;
            // The last word is being pushed this cycle.
            StFetch:    if (all_issued_q && inflight_q) state_d = StDrain;
            StDrain:    if (count_q == '0) state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Address counter: it stops at the last address instead of wrapping.
    always_comb begin
        addr_d       = addr_q;
        all_issued_d = all_issued_q;
        inflight_d   = issue;
        if ((state_q == StDone) || ((state_q == StIdle) && cpu_start)) begin
            addr_d       = '0;
            all_issued_d = 1'b0;
        end else if (issue) begin
            if (addr_q == LastAddr) begin
                all_issued_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // A push and a pop in the same cycle leave the count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            all_issued_q <= 1'b0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            all_issued_q <= all_issued_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            // The pointer width is log2(FD), so the pointers wrap modulo FD.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage needs no reset; the head is gated off while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_word;
    end

    assign cpu_valid  = (count_q != '0);
    assign cpu_data   = cpu_valid ? mem[rd_ptr_q] : '0;
    assign c_trigg    = (state_q == StTrig);
    assign ram_sel    = (state_q == StFetch) || (state_q == StDrain);
    assign ram_addr   = addr_q;
    assign busy       = (state_q != StIdle);
    assign batch_done = (state_q == StDone);

endmodule

// File: tb/tb_frame_reader.sv
// Testbench for frame_reader (WORDS=8, FD=4). Every issued batch pushes its
// expected words into a queue. A monitor pops the queue and compares on each
// accepted cpu_rd.

module tb_frame_reader;

    localparam int DW = 15;
    localparam int AW = 11;
    localparam int WORDS = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset_sync = 1'b1;
    logic          cpu_start = 1'b0;
    logic          c_trigg;
    logic          c_done = 1'b1;
    logic [AW:0]   ram_addr;
    logic [DW:0]   ram_data = '0;
    logic          ram_sel;
    logic          cpu_rd = 1'b0;
    logic [DW:0]   cpu_data;
    logic          cpu_valid;
    logic          busy;
    logic          batch_done;

    int checks = 0;
    int errors = 0;
    int done_cycles = 0;
    int k;

    logic [15:0] ram_mem [8];
    logic [15:0] exp_tab [8];
    logic [15:0] exp_q [$];

    frame_reader #(
        .DW    (DW),
        .AW    (AW),
        .WORDS (WORDS),
        .FD    (FD)
    ) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .cpu_start  (cpu_start),
        .c_trigg    (c_trigg),
        .c_done     (c_done),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_sel    (ram_sel),
        .cpu_rd     (cpu_rd),
        .cpu_data   (cpu_data),
        .cpu_valid  (cpu_valid),
        .busy       (busy),
        .batch_done (batch_done)
    );

    always #5 clk = ~clk;

    // Line RAM model: read data one cycle after the address.
    always @(posedge clk) ram_data <= ram_mem[ram_addr[2:0]];

    // Monitor: compare every accepted pop, count batch_done cycles.
    always @(negedge clk) begin
        if (!reset_sync) begin
            if (batch_done) done_cycles++;
            if (cpu_valid && cpu_rd) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got %h, required no word", cpu_data);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (cpu_data !== e) begin
                        errors++;
                        $display("FAIL pop_data: got %h, required %h", cpu_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_batch();
        for (int i = 0; i < WORDS; i++) exp_q.push_back(exp_tab[i]);
    endtask

    // Start request, capture handshake with c_done low for 3 cycles, then high.
    task automatic run_capture();
        cpu_start = 1'b1;
        step();
        cpu_start = 1'b0;
        c_done = 1'b0;
        step();
        step();
        step();
        c_done = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        ram_mem[0] = 16'h12AB; ram_mem[1] = 16'h3401; ram_mem[2] = 16'h5602;
        ram_mem[3] = 16'h7803; ram_mem[4] = 16'h9A04; ram_mem[5] = 16'hBC05;
        ram_mem[6] = 16'hDE06; ram_mem[7] = 16'hF007;
`ifdef BYTE_SWAP_EN
        exp_tab[0] = 16'hAB12; exp_tab[1] = 16'h0134; exp_tab[2] = 16'h0256;
        exp_tab[3] = 16'h0378; exp_tab[4] = 16'h049A; exp_tab[5] = 16'h05BC;
        exp_tab[6] = 16'h06DE; exp_tab[7] = 16'h07F0;
`else
        exp_tab[0] = 16'h12AB; exp_tab[1] = 16'h3401; exp_tab[2] = 16'h5602;
        exp_tab[3] = 16'h7803; exp_tab[4] = 16'h9A04; exp_tab[5] = 16'hBC05;
        exp_tab[6] = 16'hDE06; exp_tab[7] = 16'hF007;
`endif

        // Reset state
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ctrigg", 32'(c_trigg), 32'd0);
        check("rst_valid", 32'(cpu_valid), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        reset_sync = 1'b0;
        step();

        // Full batch with cpu_rd held high; c_trigg held while c_done stays high.
        cpu_rd = 1'b1;
        done_cycles = 0;
        push_batch();
        cpu_start = 1'b1;
        step();
        cpu_start = 1'b0;
        check("trig_high", 32'(c_trigg), 32'd1);
        check("trig_busy", 32'(busy), 32'd1);
        step();
        check("trig_hold", 32'(c_trigg), 32'd1);
        c_done = 1'b0;
        step();
        check("trig_release", 32'(c_trigg), 32'd0);
        step();
        step();
        check("wait_no_sel", 32'(ram_sel), 32'd0);
        c_done = 1'b1;
        step();
        check("fetch_sel", 32'(ram_sel), 32'd1);
        k = 0;
        while (!cpu_valid && k < 20) begin
            step();
            k++;
        end
        check("first_valid_latency", 32'(k), 32'd2);
        wait_idle("b1");
        check("b1_done_pulse", 32'(done_cycles), 32'd1);
        check("b1_all_read", 32'(exp_q.size()), 32'd0);

        // Underflow: pops on an empty FIFO are ignored.
        repeat (3) begin
            step();
            check("underflow_valid", 32'(cpu_valid), 32'd0);
        end

        // Backpressure: only FD words fetched while cpu_rd is low.
        cpu_rd = 1'b0;
        done_cycles = 0;
        push_batch();
        run_capture();
        repeat (20) step();
        check("stall_addr", 32'(ram_addr), 32'd4);
        check("stall_valid", 32'(cpu_valid), 32'd1);
        check("stall_sel", 32'(ram_sel), 32'd1);
        check("stall_nopop", 32'(exp_q.size()), 32'd8);
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        repeat (5) step();
        check("refill_addr", 32'(ram_addr), 32'd5);
        cpu_rd = 1'b1;
        wait_idle("b2");
        check("b2_done_pulse", 32'(done_cycles), 32'd1);
        check("b2_all_read", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a batch.
        cpu_rd = 1'b0;
        push_batch();
        run_capture();
        k = 0;
        while (ram_addr != 3 && k < 50) begin
            step();
            k++;
        end
        check("mid_addr_reached", 32'(ram_addr), 32'd3);
        reset_sync = 1'b1;
        step();
        check("mrst_ctrigg", 32'(c_trigg), 32'd0);
        check("mrst_sel", 32'(ram_sel), 32'd0);
        check("mrst_addr", 32'(ram_addr), 32'd0);
        check("mrst_valid", 32'(cpu_valid), 32'd0);
        check("mrst_data", 32'(cpu_data), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(batch_done), 32'd0);
        exp_q.delete();
        reset_sync = 1'b0;
        step();
        cpu_rd = 1'b1;
        done_cycles = 0;
        push_batch();
        run_capture();
        wait_idle("b3");
        check("b3_done_pulse", 32'(done_cycles), 32'd1);
        check("b3_all_read", 32'(exp_q.size()), 32'd0);

        // cpu_start and a c_done drop during FETCH have no effect.
        done_cycles = 0;
        push_batch();
        run_capture();
        step();
        step();
        cpu_start = 1'b1;
        c_done = 1'b0;
        step();
        cpu_start = 1'b0;
        wait_idle("b4");
        check("b4_done_pulse", 32'(done_cycles), 32'd1);
        check("b4_all_read", 32'(exp_q.size()), 32'd0);
        repeat (5) step();
        check("b4_stays_idle", 32'(busy), 32'd0);
        check("b4_no_trig", 32'(c_trigg), 32'd0);
        c_done = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
